// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Port 0 (CPU) and port 1 (loader/debug) share the memory with bounded-hold fairness.
module mem_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_we0,
    input  logic       i_we1,
    input  logic [7:0] i_addr0,
    input  logic [7:0] i_addr1,
    input  logic [7:0] i_wdata0,
    input  logic [7:0] i_wdata1,
    output logic       o_gnt0,
    output logic       o_gnt1,
    output logic       o_rvalid0,
    output logic       o_rvalid1,
    output logic [7:0] o_rdata0,
    output logic [7:0] o_rdata1,
    output logic [7:0] o_mem_addr,
    output logic [7:0] o_mem_data,
    output logic       o_mem_wren,
    output logic       o_mem_rden,
    input  logic [7:0] i_mem_q
);

    localparam logic [3:0] L_MAX_HOLD = 4'(MAX_HOLD);

    logic       r_last;
    logic [3:0] r_cnt;
    logic       r_rvalid0;
    logic       r_rvalid1;

    logic       w_pick1;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_any;
    logic       w_we;
    logic       w_last_d;
    logic [3:0] w_cnt_d;
    logic       w_rvalid0;
    logic       w_rvalid1;

    // Under contention stay on the last winner until it has held MAX_HOLD grants.
    always_comb begin
        if (i_req0 && i_req1) begin
            w_pick1 = (r_cnt < L_MAX_HOLD) ? r_last : ~r_last;
        end else begin
            w_pick1 = i_req1;
        end
    end

    assign w_gnt0 = ~i_reset & i_req0 & ~w_pick1;
    assign w_gnt1 = ~i_reset & i_req1 & w_pick1;
    assign w_any  = w_gnt0 | w_gnt1;
    assign w_we   = w_gnt1 ? i_we1 : i_we0;

    always_comb begin
        o_mem_addr = 8'h00;
        o_mem_data = 8'h00;
        if (w_gnt0) begin
            o_mem_addr = i_addr0;
            o_mem_data = i_wdata0;
        end else if (w_gnt1) begin
            o_mem_addr = i_addr1;
            o_mem_data = i_wdata1;
        end
    end

    assign o_mem_wren = w_any & w_we;
    assign o_mem_rden = w_any & ~w_we;
    assign o_gnt0     = w_gnt0;
    assign o_gnt1     = w_gnt1;

    always_comb begin
        w_last_d = r_last;
        w_cnt_d  = 4'd0;
        if (w_any) begin
            w_last_d = w_gnt1;
            if (w_gnt1 == r_last) begin
                w_cnt_d = (r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1;
            end else begin
                w_cnt_d = 4'd1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last    <= 1'b0;
            r_cnt     <= 4'd0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_last    <= w_last_d;
            r_cnt     <= w_cnt_d;
            r_rvalid0 <= w_gnt0 & ~i_we0;
            r_rvalid1 <= w_gnt1 & ~i_we1;
        end
    end

    // Masking with reset kills a response already in flight when reset arrives.
    assign w_rvalid0 = r_rvalid0 & ~i_reset;
    assign w_rvalid1 = r_rvalid1 & ~i_reset;
    assign o_rvalid0 = w_rvalid0;
    assign o_rvalid1 = w_rvalid1;
    assign o_rdata0  = w_rvalid0 ? i_mem_q : 8'h00;
    assign o_rdata1  = w_rvalid1 ? i_mem_q : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous single-port memory.
module tb_mem_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] mem_addr, mem_data, mem_q;
    logic       mem_wren, mem_rden;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.MAX_HOLD(4)) dut (
        .i_clock   (clk),
        .i_reset   (reset),
        .i_req0    (req0),
        .i_req1    (req1),
        .i_we0     (we0),
        .i_we1     (we1),
        .i_addr0   (addr0),
        .i_addr1   (addr1),
        .i_wdata0  (wdata0),
        .i_wdata1  (wdata1),
        .o_gnt0    (gnt0),
        .o_gnt1    (gnt1),
        .o_rvalid0 (rvalid0),
        .o_rvalid1 (rvalid1),
        .o_rdata0  (rdata0),
        .o_rdata1  (rdata1),
        .o_mem_addr(mem_addr),
        .o_mem_data(mem_data),
        .o_mem_wren(mem_wren),
        .o_mem_rden(mem_rden),
        .i_mem_q   (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        if (mem_rden) mem_q <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] exp_seq;
    logic       prev_g;
    logic       prev_v;
    logic [3:0] sw_seq;

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        next_cycle();
        req0 = 1; req1 = 1;
        @(negedge clk);
        chk("rst_gnt0", {7'd0, gnt0}, 8'd0);
        chk("rst_gnt1", {7'd0, gnt1}, 8'd0);
        chk("rst_rden", {7'd0, mem_rden}, 8'd0);
        chk("rst_wren", {7'd0, mem_wren}, 8'd0);
        chk("rst_addr", mem_addr, 8'd0);
        chk("rst_rvalid0", {7'd0, rvalid0}, 8'd0);

        // Port 0 writes 0x5A to 0x10, then reads it back.
        next_cycle();
        reset = 0; req1 = 0; we0 = 1; addr0 = 8'h10; wdata0 = 8'h5A;
        @(negedge clk);
        chk("p0w_gnt0", {7'd0, gnt0}, 8'd1);
        chk("p0w_wren", {7'd0, mem_wren}, 8'd1);
        chk("p0w_rden", {7'd0, mem_rden}, 8'd0);
        chk("p0w_addr", mem_addr, 8'h10);
        chk("p0w_data", mem_data, 8'h5A);
        next_cycle();
        we0 = 0;
        @(negedge clk);
        chk("p0r_gnt0", {7'd0, gnt0}, 8'd1);
        chk("p0r_gnt1", {7'd0, gnt1}, 8'd0);
        chk("p0r_rden", {7'd0, mem_rden}, 8'd1);
        chk("p0w_no_rvalid", {7'd0, rvalid0}, 8'd0);
        next_cycle();
        req0 = 0;
        @(negedge clk);
        chk("p0r_rvalid0", {7'd0, rvalid0}, 8'd1);
        chk("p0r_rdata0", rdata0, 8'h5A);
        chk("p0r_gnt1", {7'd0, gnt1}, 8'd0);
        chk("idle_rden", {7'd0, mem_rden}, 8'd0);
        chk("idle_addr", mem_addr, 8'd0);
        next_cycle();
        @(negedge clk);
        chk("p0r_rvalid_once", {7'd0, rvalid0}, 8'd0);
        chk("p0r_rdata_zero", rdata0, 8'd0);

        // Port 1 writes 0xC3 to 0x20, then reads it back.
        next_cycle();
        req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'hC3;
        @(negedge clk);
        chk("p1w_gnt1", {7'd0, gnt1}, 8'd1);
        chk("p1w_wren", {7'd0, mem_wren}, 8'd1);
        chk("p1w_addr", mem_addr, 8'h20);
        chk("p1w_data", mem_data, 8'hC3);
        next_cycle();
        we1 = 0;
        @(negedge clk);
        chk("p1r_gnt1", {7'd0, gnt1}, 8'd1);
        chk("p1r_rden", {7'd0, mem_rden}, 8'd1);
        chk("p1w_no_rvalid", {7'd0, rvalid1}, 8'd0);
        next_cycle();
        req1 = 0;
        @(negedge clk);
        chk("p1r_rvalid1", {7'd0, rvalid1}, 8'd1);
        chk("p1r_rdata1", rdata1, 8'hC3);
        chk("p1r_rvalid0", {7'd0, rvalid0}, 8'd0);

        // Idle keeps L = 1, so contention starts on port 1 for MAX_HOLD grants.
        next_cycle();
        @(negedge clk);
        chk("idle_wren", {7'd0, mem_wren}, 8'd0);
        chk("idle_rden2", {7'd0, mem_rden}, 8'd0);
        exp_seq = 10'b1100001111;
        prev_g  = 1'b0;
        prev_v  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h10; addr1 = 8'h20;
            @(negedge clk);
            chk($sformatf("both_gnt1_%0d", i), {7'd0, gnt1}, {7'd0, exp_seq[i]});
            chk($sformatf("both_gnt0_%0d", i), {7'd0, gnt0}, {7'd0, ~exp_seq[i]});
            chk($sformatf("both_rv0_%0d", i), {7'd0, rvalid0}, {7'd0, prev_v & ~prev_g});
            chk($sformatf("both_rv1_%0d", i), {7'd0, rvalid1}, {7'd0, prev_v & prev_g});
            chk($sformatf("both_rd0_%0d", i), rdata0, (prev_v & ~prev_g) ? 8'h5A : 8'h00);
            chk($sformatf("both_rd1_%0d", i), rdata1, (prev_v & prev_g) ? 8'hC3 : 8'h00);
            prev_g = exp_seq[i];
            prev_v = 1'b1;
        end

        // A port 0 read granted just before reset must never return.
        next_cycle();
        req1 = 0;
        @(negedge clk);
        chk("pre_rst_gnt0", {7'd0, gnt0}, 8'd1);
        next_cycle();
        reset = 1;
        @(negedge clk);
        chk("in_rst_rvalid0", {7'd0, rvalid0}, 8'd0);
        chk("in_rst_rdata0", rdata0, 8'd0);
        chk("in_rst_gnt0", {7'd0, gnt0}, 8'd0);
        chk("in_rst_rden", {7'd0, mem_rden}, 8'd0);
        chk("in_rst_addr", mem_addr, 8'd0);
        next_cycle();
        req1 = 1;
        @(negedge clk);
        chk("in_rst2_rvalid0", {7'd0, rvalid0}, 8'd0);
        chk("in_rst2_gnt1", {7'd0, gnt1}, 8'd0);

        // After release port 0 wins; it drops after two grants, port 1 restarts its count at 1.
        next_cycle();
        reset = 0;
        @(negedge clk);
        chk("post_rst_gnt0_a", {7'd0, gnt0}, 8'd1);
        chk("post_rst_rvalid0", {7'd0, rvalid0}, 8'd0);
        next_cycle();
        @(negedge clk);
        chk("post_rst_gnt0_b", {7'd0, gnt0}, 8'd1);
        next_cycle();
        req0 = 0;
        @(negedge clk);
        chk("sw_gnt1_a", {7'd0, gnt1}, 8'd1);
        next_cycle();
        @(negedge clk);
        chk("sw_gnt1_b", {7'd0, gnt1}, 8'd1);
        // Port 1 has cnt = 2 now: two more grants under contention, then port 0.
        sw_seq = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            req0 = 1;
            @(negedge clk);
            chk($sformatf("sw_cont_gnt1_%0d", i), {7'd0, gnt1}, {7'd0, sw_seq[i]});
            chk($sformatf("sw_cont_gnt0_%0d", i), {7'd0, gnt0}, {7'd0, ~sw_seq[i]});
        end

        next_cycle();
        req0 = 0; req1 = 0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 4, maximum consecutive grants to one port while the other port is requesting (legal range 1..15).
REQ-002 Port: clock  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req0 / req1  in  1  port 0 (CPU) / port 1 (loader/debug) access request.
REQ-005 Port: we0 / we1  in  1  1 = write, 0 = read; qualified by reqN.
REQ-006 Port: addr0 / addr1  in  8  word address.
REQ-007 Port: wdata0 / wdata1  in  8  write data.
REQ-008 Port: gnt0 / gnt1  out  1  access accepted this cycle; combinational from reqN and internal state.
REQ-009 Port: rvalid0 / rvalid1  out  1  read data valid for that port this cycle; registered.
REQ-010 Port: rdata0 / rdata1  out  8  read data; equals mem_q when rvalidN = 1, else 0.
REQ-011 Port: mem_addr  out  8  address to the single-port synchronous memory.
REQ-012 Port: mem_data  out  8  write data to memory.
REQ-013 Port: mem_wren / mem_rden  out  1  memory write / read enable.
REQ-014 Port: mem_q  in  8  memory read data, valid one cycle after mem_rden.

Function
REQ-015 At most one of gnt0/gnt1 SHALL be 1 in any cycle.
REQ-016 A port SHALL never be granted unless its req is 1.
REQ-017 Only one port requesting: that port SHALL be granted in the same cycle.
REQ-018 Both ports requesting: grant port L (last granted) if cnt < MAX_HOLD, else grant the other port.
REQ-019 State L (1 bit) SHALL update to the granted port on every grant; it is unchanged on idle cycles.
REQ-020 cnt (4 bit) update rule: +1 (saturating at 15) on a grant to the same port as L; set to 1 on a grant to the other port; set to 0 on a cycle with no grant.
REQ-021 Granted cycle: mem_addr, mem_data and mem_wren (= weN) SHALL be driven from the granted port, and mem_rden SHALL equal ~weN.
REQ-022 No grant: mem_addr = 0, mem_data = 0, mem_wren = 0, mem_rden = 0.
REQ-023 Read granted to port N in cycle t: rvalidN = 1 in cycle t+1 for exactly one cycle, with rdataN = mem_q.
REQ-024 Writes SHALL produce no rvalid.
REQ-025 Back-to-back reads, from the same or alternating ports, SHALL sustain one access per cycle, with rvalid responses in grant order.
REQ-026 Requester contract: hold req/we/addr/wdata stable until gnt is seen. The cycle after gnt, the requester presents the next transfer or drops req. The arbiter SHALL not check this contract.
REQ-027 Read and write issued in consecutive cycles to the same address: the read SHALL return the memory's behaviour unmodified; the arbiter SHALL not forward data.

Reset
REQ-028 While reset = 1: L = 0, cnt = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0, gnt0 = gnt1 = 0, all mem_* outputs = 0.
REQ-029 A read granted in the cycle before reset is asserted SHALL NOT produce an rvalid in the reset cycle or after it.
REQ-030 First cycle after reset release with both requesting: port 0 SHALL be granted (L = 0, cnt = 0).

Verification
REQ-031 Port 0 only: read addr 0x10 (memory holds 0x5A) -> gnt0 in cycle t; rvalid0 = 1 and rdata0 = 0x5A in cycle t+1; gnt1 = 0 throughout.
REQ-032 Port 1 only: write 0xC3 to 0x20, then read 0x20 -> mem_wren = 1 with mem_addr = 0x20 and mem_data = 0xC3; the read returns 0xC3 with rvalid1.
REQ-033 Both ports continuously requesting reads, MAX_HOLD = 4 -> grant sequence 0,0,0,0,1,1,1,1,0,...; each rvalid follows its grant by 1 cycle.
REQ-034 Both request after reset, with port 0 dropping req after 2 grants -> grants 0,0,1,1,... with cnt restarting at 1 on the switch.
REQ-035 Reset asserted in the cycle after a port 0 read grant -> rvalid0 stays 0; all outputs are 0 while in reset.
REQ-036 Idle cycle between bursts -> cnt = 0, L retained, no mem enables asserted.
